// File: rtl/maxpool_1_pkg.sv
// Shared constants for the LeNet-5 feature-map path and a width helper.
package maxpool_1_pkg;

   localparam int unsigned MP_DATA_SIZE = 16;

   // LeNet-5 spatial dimensions: C1 out, S2 out, C3 out, S4 out
   localparam int unsigned LENET_C1_DIM = 28;
   localparam int unsigned LENET_S2_DIM = 14;
   localparam int unsigned LENET_C3_DIM = 10;
   localparam int unsigned LENET_S4_DIM = 5;

   // Bits needed to index 'value' entries; never returns less than 1
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) w = i + 1;
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/maxpool_1_pool_line_buf.sv
// Half-row line buffer: single port, synchronous write, combinational read.
module pool_line_buf
   import maxpool_1_pkg::*;
#(
   parameter int unsigned DEPTH = LENET_S2_DIM,
   parameter int unsigned WIDTH = MP_DATA_SIZE,
   parameter int unsigned AW    = clog2(LENET_S2_DIM)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage write; contents intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= wr_data;
   end

   // Asynchronous read of the addressed entry
   always_comb begin
      rd_data = mem[addr];
   end

endmodule

// File: rtl/maxpool_1.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-order frame.
module maxpool_1
   import maxpool_1_pkg::*;
#(
   parameter int unsigned DATA_SIZE = MP_DATA_SIZE,
   parameter int unsigned IMG_W     = LENET_C1_DIM,
   parameter int unsigned IMG_H     = LENET_C1_DIM
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 din_valid,
   input  logic [DATA_SIZE-1:0] din,
   output logic                 dout_valid,
   output logic [DATA_SIZE-1:0] dout,
   output logic                 frame_done
);

   localparam int unsigned HALF_W = IMG_W / 2;
   localparam int unsigned CW     = clog2(IMG_W);
   localparam int unsigned RW     = clog2(IMG_H);
   localparam int unsigned AW     = clog2(HALF_W);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]        col_q, col_d;
   logic [RW-1:0]        row_q, row_d;
   logic [DATA_SIZE-1:0] hmax_q, hmax_d;
   logic [DATA_SIZE-1:0] dout_q, dout_d;
   logic                 dout_valid_q, dout_valid_d;
   logic                 frame_done_q, frame_done_d;

   logic [DATA_SIZE-1:0] pmax;
   logic [DATA_SIZE-1:0] win_max;
   logic [DATA_SIZE-1:0] lb_rd;
   logic [AW-1:0]        lb_addr;
   logic                 lb_wr_en;

   pool_line_buf #(
      .DEPTH (HALF_W),
      .WIDTH (DATA_SIZE),
      .AW    (AW)
   ) u_line_buf (
      .clk     (clk),
      .wr_en   (lb_wr_en),
      .addr    (lb_addr),
      .wr_data (pmax),
      .rd_data (lb_rd)
   );

   // Pair/window maxima, line-buffer control and raster counter advance
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      hmax_d       = hmax_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      frame_done_d = 1'b0;
      lb_wr_en     = 1'b0;
      lb_addr      = AW'(col_q >> 1);
      pmax         = ($signed(din) > $signed(hmax_q)) ? din : hmax_q;
      win_max      = ($signed(lb_rd) > $signed(pmax)) ? lb_rd : pmax;

      // Reset wins over a coincident pixel, including the line-buffer write
      if (din_valid && !rst) begin
         if (!col_q[0]) begin
            hmax_d = din;
         end else if (!row_q[0]) begin
            lb_wr_en = 1'b1;
         end else begin
            dout_d       = win_max;
            dout_valid_d = 1'b1;
            frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
         end

         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         hmax_q       <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hmax_q       <= hmax_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: doc/maxpool_1.md
# maxpool_1

Streaming 2×2, stride-2 max-pooling stage directly downstream of `relu_1` in the first LeNet-5 feature-map path. It consumes one rectified 16-bit pixel per valid cycle in raster order (IMG_W × IMG_H, one channel) and emits the (IMG_W/2) × (IMG_H/2) pooled map in raster order. A half-row line buffer holds partial maxima between row pairs.

## Interface
- `DATA_SIZE`, 16, pixel width, signed fixed point.
- `IMG_W`, 28, input row length in pixels; must be even and ≥ 2.
- `IMG_H`, 28, input rows per frame; must be even and ≥ 2.
- `clk` input 1, the single clock.
- `rst` input 1, synchronous, active-high reset.
- `din_valid` input 1, `din` carries a pixel this cycle.
- `din` input DATA_SIZE, pixel from `relu_1`.
- `dout_valid` output 1, `dout` carries a pooled pixel this cycle.
- `dout` output DATA_SIZE, pooled pixel.
- `frame_done` output 1, one-cycle pulse coincident with the last pooled pixel of a frame.

## Operation
- No backpressure: every cycle with `din_valid`=1 consumes one pixel. Idle cycles (`din_valid`=0) are allowed anywhere and freeze all state.
- Counters: `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each accepted pixel. `col` wraps to 0 and increments `row` at IMG_W-1. `row` wraps to 0 after the last pixel of row IMG_H-1, so the next pixel starts a new frame.
- Pair register `hmax`:
  - On even `col`, capture `din`.
  - On odd `col`, form `pmax = max(hmax, din)`.
- Even `row`, odd `col`: write `pmax` to `line_buf[col>>1]`.
- Odd `row`, odd `col`: register `max(pmax, line_buf[col>>1])` into `dout` and assert `dout_valid` for one cycle.
- All comparisons are signed two's complement at DATA_SIZE bits. There is no widening and no saturation; the output equals one of the four inputs exactly.
- `frame_done` asserts with the output at `row`=IMG_H-1, `col`=IMG_W-1.
- Line buffer: IMG_W/2 entries × DATA_SIZE.
  - Written only on even rows and read only on odd rows, so a location is never read and written in the same cycle.
  - Contents are not reset. Correctness relies only on the write-before-read ordering within each row pair.

## Timing
- Reset values: `dout`=0, `dout_valid`=0, `frame_done`=0, `col`=0, `row`=0, `hmax`=0.
- Latency: `dout_valid` rises on the clock edge after the fourth window pixel (odd row, odd column) is accepted, so 1 cycle from the last contributing input.
- Throughput: one output per 4 accepted inputs on average. Outputs occur only during odd rows, every second accepted pixel.
- `dout` holds its value between outputs; only `dout_valid` qualifies it.
- `rst` asserted mid-frame: the next edge clears counters and outputs, and any partial window is discarded. The first pixel after reset release is treated as (row 0, col 0).
- `rst` and `din_valid` in the same cycle: reset wins and the pixel is dropped.

## Structure
- Shared package/header: `DATA_SIZE`, the LeNet layer dimensions (28, 14, 10, 5), and a `clog2` helper for counter widths.
- Sub-module `pool_line_buf`: a single-port, IMG_W/2-deep, DATA_SIZE-wide register array with synchronous write and combinational read, so it can later map to distributed RAM.
- Top level holds the counters, `hmax`, the comparators and the output register.

## Test plan
- Reset then a 28×28 ramp `din = row*28 + col`, continuous valid:
  - 196 outputs, output (r,c) = (2r+1)*28 + 2c + 1.
  - `frame_done` asserted only on the 196th output.
- 4×4 frame (IMG_W=IMG_H=4), rows {1,5,2,0},{3,0,9,7},{0,0,0,0},{8,0,0,6} → outputs 5, 9, 8, 6, each one cycle after its fourth window pixel.
- Signed ordering, 4×4: a window of 0x8000, 0xFFFF, 0x0001, 0x0000 → 0x0001; an all-negative window of 0x8000, 0xFFF0, 0xFFFE, 0x9000 → 0xFFFE.
- Random `din_valid` gaps (≈50% duty) on the ramp frame → the same 196 values in the same order as the continuous case, with no extra `dout_valid` pulses.
- `rst` asserted after 40 pixels, then a fresh ramp frame:
  - no output appears during reset;
  - the following frame's outputs match the first scenario exactly.
- Two back-to-back frames with no idle cycle → the second frame's outputs are identical to the first, and `frame_done` pulses twice.
